// File: rtl/traffic_pkg.sv
// Shared phase encoding and default timing for the traffic light controller.
package traffic_pkg;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} phase_e;

  localparam int DEF_N_CH     = 2;
  localparam int DEF_GREEN_T  = 9;
  localparam int DEF_YELLOW_T = 3;
  localparam int DEF_ALLRED_T = 2;
  localparam int DEF_TICK_DIV = 2**23;
  localparam int DEF_CNT_W    = 4;
endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Request/lamp bundle between the environment (master) and the controller (slave).
interface traffic_light_ctrl_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 4
);
  localparam int AW = $clog2(N_CH);

  logic [N_CH-1:0]  btn;
  logic [N_CH-1:0]  R;
  logic [N_CH-1:0]  Y;
  logic [N_CH-1:0]  G;
  logic [CNT_W-1:0] count;
  logic [AW-1:0]    active;

  modport master (output btn, input R, Y, G, count, active);
  modport slave  (input btn, output R, Y, G, count, active);
endinterface

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Free-running prescaler; tick pulses for one clk on the last count before wrap.
module tick_gen #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + W'(1);
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light phase controller with latched per-channel requests.
// Define TRAFFIC_ALLRED_EN to build the all-red clearance phase after yellow.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int GREEN_T  = DEF_GREEN_T,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 reset,
  traffic_light_ctrl_if.slave bus
);
  localparam int AW = $clog2(N_CH);

  phase_e           state_q, state_d;
  logic [AW-1:0]    act_q, act_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  pend_q, pend_d, gmask;
  logic [N_CH-1:0]  r_q, r_d, y_q, y_d, g_q, g_d;
  logic             tick, grant, found;
  int               idx;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  always_comb begin
    // first pending channel after the current owner; the owner itself is checked last
    nxt   = act_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(act_q) + k) % N_CH;
      if (!found && pend_q[AW'(idx)]) begin
        found = 1'b1;
        nxt   = AW'(idx);
      end
    end

    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    if (tick) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else begin
        case (state_q)
          GREEN: begin
            if (|pend_q) begin
              state_d = YELLOW;
              cnt_d   = CNT_W'(YELLOW_T - 1);
            end else cnt_d = CNT_W'(GREEN_T - 1);
          end
`ifdef TRAFFIC_ALLRED_EN
          YELLOW: begin
            state_d = ALLRED;
            cnt_d   = CNT_W'(ALLRED_T - 1);
          end
          default: grant = 1'b1;
`else
          default: grant = 1'b1;
`endif
        endcase
      end
    end
    if (grant) begin
      state_d = GREEN;
      act_d   = nxt;
      cnt_d   = CNT_W'(GREEN_T - 1);
    end

    gmask = '0;
    if (state_q == GREEN) gmask[act_q] = 1'b1;
    pend_d = pend_q | (bus.btn & ~gmask);
    if (grant) pend_d[act_d] = 1'b0;

    // lamps follow the next state so they are registered with it
    r_d = '0;
    y_d = '0;
    g_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (AW'(i) == act_d && state_d == GREEN)       g_d[i] = 1'b1;
      else if (AW'(i) == act_d && state_d == YELLOW) y_d[i] = 1'b1;
      else                                           r_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GREEN;
      act_q   <= '0;
      cnt_q   <= CNT_W'(GREEN_T - 1);
      pend_q  <= '0;
      g_q     <= N_CH'(1);
      y_q     <= '0;
      r_q     <= ~N_CH'(1);
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      g_q     <= g_d;
      y_q     <= y_d;
      r_q     <= r_d;
    end
  end

  assign bus.R      = r_q;
  assign bus.Y      = y_q;
  assign bus.G      = g_q;
  assign bus.count  = cnt_q;
  assign bus.active = act_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: N_CH=3, GREEN_T=4, YELLOW_T=2, ALLRED_T=1, TICK_DIV=4.
module tb_traffic_light_ctrl;
  localparam int N_CH = 3;
  localparam int GT   = 4;
  localparam int YT   = 2;
  localparam int AT   = 1;
  localparam int TD   = 4;
  localparam int CW   = 4;
`ifdef TRAFFIC_ALLRED_EN
  localparam int AR = AT * TD;
`else
  localparam int AR = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   now_e = 0;
  int   g1, g2;

  traffic_light_ctrl_if #(.N_CH(N_CH), .CNT_W(CW)) bus ();

  traffic_light_ctrl #(
    .N_CH(N_CH), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .TICK_DIV(TD), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [2:0] g, input logic [2:0] y,
                    input logic [2:0] r, input int cnt, input int act);
    chk({tag, ".G"}, 32'(bus.G), 32'(g));
    chk({tag, ".Y"}, 32'(bus.Y), 32'(y));
    chk({tag, ".R"}, 32'(bus.R), 32'(r));
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    chk({tag, ".active"}, 32'(bus.active), 32'(act));
  endtask

  // edge n = n-th rising edge after reset release; sampled 1 time unit later
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    now_e += n;
  endtask

  task automatic to(input int e);
    adv(e - now_e);
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    bus.btn = '0;
    repeat (2) @(posedge clk);
    #1;
    st("reset", 3'b001, 3'b000, 3'b110, GT - 1, 0);
    reset = 1'b0;
    now_e = 0;
  endtask

  task automatic pulse(input logic [2:0] b, input int e);
    to(e);
    bus.btn = b;
    adv(1);
    bus.btn = '0;
  endtask

  initial begin
    bus.btn = '0;

    // idle: ch0 keeps green, count cycles 3,2,1,0,3 every TD clocks
    do_reset;
    for (int t = 0; t <= 10; t++) begin
      to(4 * t);
      st($sformatf("idle.t%0d", t), 3'b001, 3'b000, 3'b110, 3 - (t % 4), 0);
    end

    // request on ch2 during ch0 green
    do_reset;
    pulse(3'b100, 4);
    to(15);  st("b2.gend", 3'b001, 3'b000, 3'b110, 0, 0);
    to(16);  st("b2.y0",   3'b000, 3'b001, 3'b110, 1, 0);
    to(23);  st("b2.y1",   3'b000, 3'b001, 3'b110, 0, 0);
    to(24);  st("b2.e24", (AR > 0) ? 3'b000 : 3'b100, 3'b000, (AR > 0) ? 3'b111 : 3'b011,
                (AR > 0) ? 0 : 3, (AR > 0) ? 0 : 2);
    to(24 + AR);      st("b2.grant", 3'b100, 3'b000, 3'b011, 3, 2);
    to(24 + AR + 16); st("b2.hold",  3'b100, 3'b000, 3'b011, 3, 2);

    // ch1 and ch2 together: round robin grants ch1 then ch2, then ch2 holds
    do_reset;
    pulse(3'b110, 4);
    g1 = 24 + AR;
    to(g1);      st("b12.g1",   3'b010, 3'b000, 3'b101, 3, 1);
    to(g1 + 16); st("b12.y1",   3'b000, 3'b010, 3'b101, 1, 1);
    g2 = g1 + 24 + AR;
    to(g2);      st("b12.g2",   3'b100, 3'b000, 3'b011, 3, 2);
    to(g2 + 16); st("b12.hold", 3'b100, 3'b000, 3'b011, 3, 2);

    // own-channel request while green is ignored
    do_reset;
    pulse(3'b001, 4);
    to(16); st("b0.exp",  3'b001, 3'b000, 3'b110, 3, 0);
    to(20); st("b0.next", 3'b001, 3'b000, 3'b110, 2, 0);

    // reset in yellow aborts immediately and drops pending requests
    do_reset;
    pulse(3'b010, 4);
    to(17); st("ry.yel", 3'b000, 3'b001, 3'b110, 1, 0);
    reset = 1'b1;
    #1;
    st("ry.async", 3'b001, 3'b000, 3'b110, 3, 0);
    do_reset;
    to(16); st("ry.pend", 3'b001, 3'b000, 3'b110, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
